// File: rtl/merge_sync_fifo5b.sv
// Synchronising sink for the 5-input mutex merge: event -> FIFO push -> one-cycle o_free ack.
// Latency: push and o_free on the 3rd edge after i_drive is first sampled; pushed entry visible at once.
// Backpressure: when full the event parks in a hold register; it is pushed and acked on the next pop.
module merge_sync_fifo5b #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_drive,
    input  logic [WIDTH-1:0]           i_data,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HOLD, ACK} state_t;

    state_t           state, state_nxt;
    logic             s1, s2, s3;
    logic             evt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hold_dat;
    logic [WIDTH-1:0] push_dat;
    logic             push, pop, space, hold_ld;

    assign evt     = s2 & ~s3;
    assign o_valid = (count != '0);
    assign pop     = o_valid & i_ready;
    // A pop in the same cycle frees the slot the push is about to use.
    assign space   = (count < CW'(DEPTH)) | pop;
    assign o_data  = o_valid ? mem[rptr] : '0;
    assign o_count = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_drive;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        hold_ld   = 1'b0;
        push_dat  = i_data;
        case (state)
            IDLE: begin
                if (evt) begin
                    if (space) begin
                        push      = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        hold_ld   = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                push_dat = hold_dat;
                if (space) begin
                    push      = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // o_free is registered from the next state so it tracks ACK exactly and cannot glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            o_free   <= 1'b0;
            o_err    <= 1'b0;
            hold_dat <= '0;
        end else begin
            state  <= state_nxt;
            o_free <= (state_nxt == ACK);
            if (evt && (state != IDLE))
                o_err <= 1'b1;
            if (hold_ld)
                hold_dat <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: o_data is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_dat;
    end
endmodule

// File: tb/tb_merge_sync_fifo5b.sv
// Self-checking bench for merge_sync_fifo5b: directed tables, corner sequences and a random scoreboard run.
module tb_merge_sync_fifo5b;
    logic       clk = 1'b0;
    logic       rst;
    logic       i_drive;
    logic [4:0] i_data;
    logic       o_free;
    logic       o_valid;
    logic [4:0] o_data;
    logic       i_ready;
    logic [2:0] o_count;
    logic       o_err;

    merge_sync_fifo5b #(.WIDTH(5), .DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_drive (i_drive),
        .i_data  (i_data),
        .o_free  (o_free),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_count (o_count),
        .o_err   (o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] dat;
        int         exp_cnt;
        int         exp_free;
    } ev_vec_t;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];
    int         occ = 0;
    logic [4:0] cur_dat = '0;
    int         free_cnt = 0;
    int         max_cnt = 0;
    bit         prev_free = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // One clock: score any pop at this edge, then account for a push (o_free rising) after it.
    task automatic tick();
        bit         pop;
        logic [4:0] hd;
        pop = o_valid && i_ready;
        hd  = o_data;
        if (pop) begin
            got_q.push_back(hd);
            if (exp_q.size() == 0) chk("pop_from_empty_model", 1, 0);
            else chk("pop_data", hd, exp_q.pop_front());
        end
        @(posedge clk);
        #1;
        if (pop) occ--;
        if (o_free) begin
            free_cnt++;
            occ++;
            exp_q.push_back(cur_dat);
            chk("free_single_cycle", prev_free, 0);
        end
        prev_free = o_free;
        chk("count", o_count, occ);
        chk("valid", o_valid, occ != 0);
        if (occ == 0) chk("empty_data_zero", o_data, 0);
        if (o_count > max_cnt) max_cnt = o_count;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        i_drive = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        #3;
        chk("rst_free", o_free, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_count", o_count, 0);
        chk("rst_err", o_err, 0);
        occ = 0;
        exp_q.delete();
        got_q.delete();
        prev_free = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_fixed(input logic [4:0] dat, input int hi, input int lo, input bit track);
        i_data = dat;
        if (track) cur_dat = dat;
        i_drive = 1'b1;
        repeat (hi) tick();
        i_drive = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        ev_vec_t    ev_tab[5];
        logic [4:0] drain_tab[4];
        bit         seen;
        int         n;
        logic [4:0] d;

        ev_tab[0] = '{dat: 5'd1, exp_cnt: 1, exp_free: 1};
        ev_tab[1] = '{dat: 5'd2, exp_cnt: 2, exp_free: 1};
        ev_tab[2] = '{dat: 5'd3, exp_cnt: 3, exp_free: 1};
        ev_tab[3] = '{dat: 5'd4, exp_cnt: 4, exp_free: 1};
        ev_tab[4] = '{dat: 5'd5, exp_cnt: 4, exp_free: 0};
        drain_tab[0] = 5'd2;
        drain_tab[1] = 5'd3;
        drain_tab[2] = 5'd4;
        drain_tab[3] = 5'd5;

        // Single event: o_free high only after E2
        do_reset();
        i_data  = 5'h13;
        cur_dat = 5'h13;
        i_drive = 1'b1;
        tick(); chk("t1_free_e0", o_free, 0);
        tick(); chk("t1_free_e1", o_free, 0);
        tick(); chk("t1_free_e2", o_free, 1);
        tick(); chk("t1_free_e3", o_free, 0);
        i_drive = 1'b0;
        repeat (2) tick();
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, 5'h13);
        chk("t1_count", o_count, 1);

        // Fill to DEPTH, fifth event parks in hold
        do_reset();
        for (int i = 0; i < 5; i++) begin
            free_cnt = 0;
            send_fixed(ev_tab[i].dat, 4, 3, 1'b1);
            chk("t2_count", o_count, ev_tab[i].exp_cnt);
            chk("t2_free", free_cnt, ev_tab[i].exp_free);
        end
        free_cnt = 0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        repeat (3) tick();
        chk("t2_hold_free", free_cnt, 1);
        chk("t2_hold_count", o_count, 4);
        got_q.delete();
        i_ready = 1'b1;
        repeat (4) tick();
        i_ready = 1'b0;
        chk("t2_drain_n", got_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            d = (i < got_q.size()) ? got_q[i] : 5'h1f;
            chk("t2_drain_data", d, drain_tab[i]);
        end
        chk("t2_count_end", o_count, 0);

        // Continuous ready, 10 back-to-back events
        do_reset();
        i_ready = 1'b1;
        max_cnt = 0;
        for (int i = 0; i < 10; i++) send_fixed(5'(i), 3, 2, 1'b1);
        repeat (3) tick();
        chk("t3_n", got_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            d = (i < got_q.size()) ? got_q[i] : 5'h1f;
            chk("t3_order", d, i);
        end
        chk("t3_max_count_le1", max_cnt <= 1, 1);

        // Second rise while holding
        do_reset();
        free_cnt = 0;
        for (int i = 1; i <= 5; i++) send_fixed(5'(i), 4, 3, 1'b1);
        chk("t4_err_before", o_err, 0);
        chk("t4_free_fill", free_cnt, 4);
        free_cnt = 0;
        send_fixed(5'h1f, 4, 3, 1'b0);
        chk("t4_err_set", o_err, 1);
        chk("t4_count", o_count, 4);
        chk("t4_no_free", free_cnt, 0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        repeat (4) tick();
        chk("t4_one_free", free_cnt, 1);
        chk("t4_err_sticky", o_err, 1);
        i_ready = 1'b1;
        repeat (5) tick();
        i_ready = 1'b0;
        chk("t4_model_empty", exp_q.size(), 0);
        chk("t4_err_still", o_err, 1);

        // Reset while in ACK with entries queued
        do_reset();
        send_fixed(5'd9, 4, 3, 1'b1);
        send_fixed(5'd10, 4, 3, 1'b1);
        i_data  = 5'd7;
        cur_dat = 5'd7;
        i_drive = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (o_free) seen = 1'b1;
        end
        chk("t5_reached_ack", seen, 1);
        do_reset();
        free_cnt = 0;
        repeat (6) tick();
        chk("t5_no_free", free_cnt, 0);
        chk("t5_count", o_count, 0);

        // Ready while empty
        do_reset();
        i_ready = 1'b1;
        repeat (3) tick();
        chk("t6_count", o_count, 0);
        chk("t6_data", o_data, 0);
        chk("t6_valid", o_valid, 0);

        // Random traffic against the scoreboard
        do_reset();
        max_cnt = 0;
        for (int e = 0; e < 30; e++) begin
            d       = 5'($urandom);
            i_data  = d;
            cur_dat = d;
            i_drive = 1'b1;
            seen = 1'b0;
            n = 0;
            while (!seen && n < 300) begin
                i_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
                if (o_free) seen = 1'b1;
            end
            chk("rnd_ack", seen, 1);
            i_drive = 1'b0;
            repeat ($urandom_range(2, 4)) begin
                i_ready = 1'($urandom_range(0, 1));
                tick();
            end
        end
        i_ready = 1'b1;
        repeat (8) tick();
        chk("rnd_model_empty", exp_q.size(), 0);
        chk("rnd_count", o_count, 0);
        chk("rnd_max_le_depth", max_cnt <= 4, 1);
        chk("rnd_err", o_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
